mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_wdog.sv | 35 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, data
// access mode encoding and port identifiers.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    MODE_WORD = 1'b0,
    MODE_BYTE = 1'b1
  } d_mode_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Memory-wait watchdog: counts enabled cycles and flags the cycle in which
// the count would reach the limit.
module wdog_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the limit-th waiting cycle so the transfer ends exactly there.
  assign expired = enable && !clear && ((cnt_q + 8'd1) == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory, alternating on contention and bounding memory waits with a watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int WORD_WIDTH     = `WORD_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_valid,
  output logic [WORD_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic                  d_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic                  d_valid,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  port_e                 last_q, last_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_mode_q, mem_mode_d;
  logic                  i_valid_q, i_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic in_grant;
  logic wd_expired;
  logic i_req_eff;
  logic d_req_eff;

  assign in_grant = (state_q != IDLE);
  // A requester still holds req during its own valid cycle; ignore it there.
  assign i_req_eff = i_req & ~i_valid_q;
  assign d_req_eff = d_req & ~d_valid_q;

  wdog_counter u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~in_grant),
    .enable  (in_grant & ~mem_ack),
    .limit   (LIMIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = mem_write_q;
    mem_mode_d  = mem_mode_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_eff && (!i_req_eff || last_q == PORT_I)) begin
          state_d     = GRANT_D;
          last_d      = PORT_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_write_d = d_write;
          mem_mode_d  = d_mode;
        end else if (i_req_eff) begin
          state_d     = GRANT_I;
          last_d      = PORT_I;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_write_d = 1'b0;
          mem_mode_d  = logic'(MODE_WORD);
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack || wd_expired) begin
          state_d = IDLE;
          err_d   = ~mem_ack;
          if (state_q == GRANT_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_I;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_mode_q  <= 1'b0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_mode_q  <= mem_mode_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = in_grant;
  assign mem_write = mem_write_q;
  assign mem_mode  = mem_mode_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, write, watchdog, reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_valid;
  logic [WW-1:0] i_rdata;
  logic          d_req = 1'b0, d_write = 1'b0, d_mode = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [WW-1:0] d_wdata = '0;
  logic          d_valid;
  logic [WW-1:0] d_rdata;
  logic          err;
  logic          mem_req, mem_write, mem_mode;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [WW-1:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_mode(d_mode), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_write(mem_write), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_mode = 1'b0;
    mem_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    do_reset();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_err", err, 0);

    // single fetch, ack in cycle 1
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_write", mem_write, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("f_i_valid", i_valid, 1);
    chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("f_err", err, 0);
    chk("f_mem_req_drop", mem_req, 0);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();
    chk("f_i_valid_low", i_valid, 0);
    chk("f_i_rdata_hold", i_rdata, 32'hDEADBEEF);
    $display("txn fetch addr=100 rdata=%0h err=%0b", i_rdata, err);

    // watchdog expiry: 15 waiting cycles then err
    i_req = 1'b1; i_addr = 32'h104;
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("wd_mem_req_c%0d", k), mem_req, 1);
      tick();
    end
    chk("wd_mem_req_drop", mem_req, 0);
    chk("wd_i_valid", i_valid, 1);
    chk("wd_err", err, 1);
    chk("wd_i_rdata", i_rdata, 0);
    i_req = 1'b0;
    tick();
    chk("wd_err_clear", err, 0);
    chk("wd_i_valid_low", i_valid, 0);
    $display("txn timeout addr=104");

    // ack on the 15th waiting cycle wins
    i_req = 1'b1; i_addr = 32'h108;
    tick();
    for (int k = 1; k <= 14; k++) tick();
    chk("wd15_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h5555;
    tick();
    chk("wd15_i_valid", i_valid, 1);
    chk("wd15_err", err, 0);
    chk("wd15_i_rdata", i_rdata, 32'h5555);
    i_req = 1'b0; mem_ack = 1'b0;
    tick();
    $display("txn late-ack addr=108 rdata=%0h", i_rdata);

    // contention after reset: D first, then alternate D,I,D,I
    do_reset();
    i_addr = 32'h100; d_addr = 32'h200;
    i_req = 1'b1; d_req = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      logic is_d;
      is_d = (g % 2 == 0);
      chk($sformatf("arb_mem_req_g%0d", g), mem_req, 1);
      chk($sformatf("arb_mem_addr_g%0d", g), mem_addr, is_d ? 32'h200 : 32'h100);
      mem_ack = 1'b1; mem_rdata = 32'h1000 + g;
      tick();
      chk($sformatf("arb_d_valid_g%0d", g), d_valid, is_d);
      chk($sformatf("arb_i_valid_g%0d", g), i_valid, !is_d);
      $display("txn arb grant=%s rdata=%0h", is_d ? "D" : "I", is_d ? d_rdata : i_rdata);
      mem_ack = 1'b0;
      if (g == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      tick();
    end
    chk("arb_idle_after", mem_req, 0);

    // data word write with deassert mid-transfer and a 2-cycle ack
    d_req = 1'b1; d_write = 1'b1; d_mode = 1'b0;
    d_addr = 32'h40; d_wdata = 32'h12345678;
    tick();
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_mode", mem_mode, 0);
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    d_req = 1'b0;
    tick();
    chk("wr_mem_req_wait", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hAB;
    tick();
    chk("wr_d_valid", d_valid, 1);
    chk("wr_d_rdata", d_rdata, 32'hAB);
    chk("wr_err", err, 0);
    mem_ack = 1'b0;
    tick();
    chk("wr_d_rdata_hold", d_rdata, 32'hAB);
    $display("txn write addr=40 wdata=12345678");

    // byte-mode read
    d_req = 1'b1; d_write = 1'b0; d_mode = 1'b1; d_addr = 32'h41;
    tick();
    chk("br_mem_mode", mem_mode, 1);
    chk("br_mem_write", mem_write, 0);
    chk("br_mem_addr", mem_addr, 32'h41);
    mem_ack = 1'b1; mem_rdata = 32'h7F;
    tick();
    chk("br_d_valid", d_valid, 1);
    chk("br_d_rdata", d_rdata, 32'h7F);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    $display("txn byte-read addr=41 rdata=%0h", d_rdata);

    // reset during GRANT_D
    d_req = 1'b1; d_write = 1'b1; d_mode = 1'b0;
    d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
    tick();
    chk("rs_mem_req_pre", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_mem_req", mem_req, 0);
    chk("rs_mem_write", mem_write, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_mem_wdata", mem_wdata, 0);
    chk("rs_d_rdata", d_rdata, 0);
    chk("rs_err", err, 0);
    mem_ack = 1'b1;
    tick();
    d_req = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rs_no_d_valid_%0d", k), d_valid, 0);
      chk($sformatf("rs_no_mem_req_%0d", k), mem_req, 0);
    end
    $display("txn reset-in-flight discarded");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
